seq_dtc_scan_ctrl: RTL and testbench
====================================

Name: seq_dtc_scan_ctrl

Overview:
Sequencing controller for the serial pattern detector (pattern 0-1-1-1-1-1-0, overlapping; detector flag w high while it sits in its final state). It accepts a parallel word through a start/busy/done handshake, clears the detector, and shifts the word into the detector's j input MSB first, one bit per clock. It counts the detections and records the bit index of the first detection. It sits between the register-level requester and the single shared detector instance.

Parameters:
WORD_W, 16, bits per scanned word (>= 2)
IDX_W, 4, width of bit index; must satisfy 2^IDX_W >= WORD_W
CNT_W, 5, width of hit counter (saturating)

Ports:
clk  in  1  clock
rst  in  1  reset: asynchronous, active-high; clock clk
start  in  1  request scan of data_in; sampled only in IDLE
data_in  in  WORD_W  word to scan, captured on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when results are valid
hit_count  out  CNT_W  number of detections in last scan, saturating
hit_valid  out  1  at least one detection in last scan
first_hit_idx  out  IDX_W  index (0 = MSB bit) of the last pattern bit of the first detection
det_rst  out  1  synchronous clear pulse to detector (top level ORs it with rst)
j_out  out  1  serial bit to detector j input
w_in  in  1  detector w output

Behaviour:
- Reset: state IDLE; busy=0, done=0, hit_count=0, hit_valid=0, first_hit_idx=0, det_rst=0, j_out=1; shift register and index counter are 0.
- States: IDLE, CLR, SHIFT, DRAIN, DONE. All outputs are registered. busy = (state != IDLE).
- IDLE: start=1 -> capture data_in into shift register; clear hit_count, hit_valid, first_hit_idx; go to CLR. start=0 -> stay. Results from the previous scan hold in IDLE.
- CLR (1 cycle): det_rst=1, j_out=1; idx=0; go to SHIFT.
- SHIFT (WORD_W cycles, idx 0..WORD_W-1): j_out = shreg[WORD_W-1]; shift left by 1 each cycle; idx increments. After idx=WORD_W-1 -> DRAIN.
- Detector latency: the bit presented in cycle k updates the detector at the end of cycle k. A w caused by bit k is visible in cycle k+1.
- Hit sampling: w_in=1 in SHIFT with idx=i (i>=1) counts as a hit ending at bit i-1. w_in is ignored in SHIFT idx 0. w_in=1 in DRAIN counts as a hit ending at bit WORD_W-1.
- On each hit: hit_count increments, saturating at 2^CNT_W-1. On the first hit only: hit_valid <= 1 and first_hit_idx <= bit index.
- DRAIN (1 cycle): j_out=1; final w sample; go to DONE.
- DONE (1 cycle): done=1; go to IDLE.
- Timing: start accepted at edge e0 -> CLR in cycle e0+1. done is high in the cycle following edge e0+WORD_W+2 (WORD_W+3 edges after e0, counting e0). The next start can be accepted the cycle after DONE.
- start while busy: ignored, not queued. data_in changes while busy have no effect.
- j_out=1 whenever not in SHIFT; the detector idles in its initial state.
- rst mid-scan: immediate return to reset values. No done pulse; partial results discarded.
- det_rst is asserted only in CLR, never in any other state.

Test Plan:
- WORD_W=16: start with data_in=16'h7DF0 -> after WORD_W+3 edges done=1, hit_count=2, hit_valid=1, first_hit_idx=6 (second hit at idx 12); busy high from CLR through DONE.
- data_in=16'hFFFF and 16'h0000 -> hit_count=0, hit_valid=0, first_hit_idx=0; j_out trace matches data MSB first.
- data_in=16'h003E -> single hit at last bit, sampled in DRAIN: hit_count=1, first_hit_idx=15.
- WORD_W=32, IDX_W=5, CNT_W=2: data_in=32'h7DF7DF7D -> hits at 6,12,18,24,30; hit_count saturates at 3; first_hit_idx=6.
- start pulsed during SHIFT with different data_in -> ignored; results match the original word; two back-to-back scans each produce exactly one done pulse and det_rst pulse.
- rst asserted mid-SHIFT -> all outputs return to reset values asynchronously; no done pulse; a fresh scan afterwards gives correct results.

Source files
------------

// File: rtl/seq_dtc_scan_ctrl.sv
// seq_dtc_scan_ctrl
//   Sequencer for the shared serial pattern detector (pattern 0111110,
//   overlapping). It accepts a word on a start/busy/done handshake, clears the
//   detector, and shifts the word into the detector MSB first, one bit per
//   clock. It counts detections (saturating) and records the bit index of the
//   first detection.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start          scan request, honoured only while idle
//   data_in        word to scan, captured when start is accepted
//   busy           high in every state except IDLE
//   done           one-cycle pulse when the results below are valid
//   hit_count      detections in the last scan, saturating
//   hit_valid      at least one detection in the last scan
//   first_hit_idx  bit index (0 = MSB) of the last pattern bit of the first hit
//   det_rst        synchronous clear pulse to the detector
//   j_out          serial bit to the detector j input
//   w_in           detector w output
module seq_dtc_scan_ctrl #(
  parameter int WORD_W = 16,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hit_count,
  output logic              hit_valid,
  output logic [IDX_W-1:0]  first_hit_idx,
  output logic              det_rst,
  output logic              j_out,
  input  logic              w_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t              state_q;
  logic [WORD_W-1:0]   shreg_q;
  logic [IDX_W-1:0]    idx_q;
  logic                busy_q;
  logic                done_q;
  logic [CNT_W-1:0]    hit_count_q;
  logic                hit_valid_q;
  logic [IDX_W-1:0]    first_hit_idx_q;
  logic                det_rst_q;
  logic                j_out_q;

  logic                hit_d;
  logic [IDX_W-1:0]    hit_pos_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // The detector answers one cycle late: w seen at SHIFT index i belongs to
  // bit i-1, and the sample taken in DRAIN belongs to the last bit.
  always_comb begin
    hit_d     = 1'b0;
    hit_pos_d = '0;
    if (state_q == S_SHIFT && idx_q != '0) begin
      hit_d     = w_in;
      hit_pos_d = idx_q - IDX_W'(1);
    end else if (state_q == S_DRAIN) begin
      hit_d     = w_in;
      hit_pos_d = LAST_IDX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      shreg_q         <= '0;
      idx_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      hit_count_q     <= '0;
      hit_valid_q     <= 1'b0;
      first_hit_idx_q <= '0;
      det_rst_q       <= 1'b0;
      j_out_q         <= 1'b1;
    end else begin
      done_q    <= 1'b0;
      det_rst_q <= 1'b0;

      if (hit_d) begin
        hit_count_q <= sat_inc(hit_count_q);
        if (!hit_valid_q) begin
          hit_valid_q     <= 1'b1;
          first_hit_idx_q <= hit_pos_d;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            shreg_q         <= data_in;
            idx_q           <= '0;
            hit_count_q     <= '0;
            hit_valid_q     <= 1'b0;
            first_hit_idx_q <= '0;
            busy_q          <= 1'b1;
            det_rst_q       <= 1'b1;
            j_out_q         <= 1'b1;
            state_q         <= S_CLR;
          end
        end
        S_CLR: begin
          // Present bit 0 during the first SHIFT cycle.
          j_out_q <= shreg_q[WORD_W-1];
          shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
          idx_q   <= '0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (idx_q == LAST_IDX) begin
            j_out_q <= 1'b1;
            state_q <= S_DRAIN;
          end else begin
            j_out_q <= shreg_q[WORD_W-1];
            shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
            idx_q   <= idx_q + IDX_W'(1);
          end
        end
        S_DRAIN: begin
          j_out_q <= 1'b1;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          j_out_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign hit_count     = hit_count_q;
  assign hit_valid     = hit_valid_q;
  assign first_hit_idx = first_hit_idx_q;
  assign det_rst       = det_rst_q;
  assign j_out         = j_out_q;

endmodule

// File: tb/tb_seq_dtc_scan_ctrl.sv
module tb_seq_dtc_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 16-bit instance
  logic        start16;
  logic [15:0] din16;
  logic        busy16, done16, hv16, dr16, j16, w16;
  logic [4:0]  cnt16;
  logic [3:0]  fi16;

  // 32-bit instance with a 2-bit counter
  logic        start32;
  logic [31:0] din32;
  logic        busy32, done32, hv32, dr32, j32, w32;
  logic [1:0]  cnt32;
  logic [4:0]  fi32;

  seq_dtc_scan_ctrl #(.WORD_W(16), .IDX_W(4), .CNT_W(5)) u16 (
    .clk(clk), .rst(rst), .start(start16), .data_in(din16),
    .busy(busy16), .done(done16), .hit_count(cnt16), .hit_valid(hv16),
    .first_hit_idx(fi16), .det_rst(dr16), .j_out(j16), .w_in(w16)
  );

  seq_dtc_scan_ctrl #(.WORD_W(32), .IDX_W(5), .CNT_W(2)) u32 (
    .clk(clk), .rst(rst), .start(start32), .data_in(din32),
    .busy(busy32), .done(done32), .hit_count(cnt32), .hit_valid(hv32),
    .first_hit_idx(fi32), .det_rst(dr32), .j_out(j32), .w_in(w32)
  );

  // Detector models: w is high while the last seven bits since clear are 0111110.
  logic [6:0] h16, h32;
  int         n16, n32;
  always @(posedge clk or posedge rst) begin
    if (rst || dr16) begin
      h16 <= '0; n16 <= 0;
    end else begin
      h16 <= {h16[5:0], j16};
      if (n16 < 7) n16 <= n16 + 1;
    end
  end
  always @(posedge clk or posedge rst) begin
    if (rst || dr32) begin
      h32 <= '0; n32 <= 0;
    end else begin
      h32 <= {h32[5:0], j32};
      if (n32 < 7) n32 <= n32 + 1;
    end
  end
  assign w16 = (n16 >= 7) && (h16 == 7'b0111110);
  assign w32 = (n32 >= 7) && (h32 == 7'b0111110);

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected results: walk the word MSB first; a hit ends at bit i when bits
  // i-6..i read 0111110.
  function automatic void ref_scan(input logic [31:0] d, input int w, input int cmax,
                                   output int cnt, output int first);
    logic [6:0] win;
    cnt   = 0;
    first = 0;
    for (int i = 6; i < w; i++) begin
      win = 7'(d >> (w - 1 - i));
      if (win == 7'b0111110) begin
        if (cnt == 0) first = i;
        if (cnt < cmax) cnt++;
      end
    end
  endfunction

  task automatic scan16(input logic [15:0] d, input int glitch);
    int rc, rf, done_at, dr_n, done_n;
    logic [15:0] jtr;
    bit busy_ok, jidle_ok;
    ref_scan({16'h0, d}, 16, 31, rc, rf);
    done_at = 0; dr_n = 0; done_n = 0; jtr = '0; busy_ok = 1; jidle_ok = 1;
    @(negedge clk);
    start16 = 1'b1; din16 = d;
    @(posedge clk);
    #1 start16 = 1'b0; din16 = 16'($urandom);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (!busy16) busy_ok = 0;
      if (dr16) dr_n++;
      if (done16) begin done_n++; done_at = c; end
      if (c >= 2 && c <= 17) jtr[17-c] = j16;
      if ((c == 1 || c >= 18) && j16 !== 1'b1) jidle_ok = 0;
      if (c == 1) chk("det_rst_in_clr", int'(dr16), 1);
      if (c == glitch) begin start16 = 1'b1; din16 = ~d; end
      else start16 = 1'b0;
    end
    start16 = 1'b0;
    chk("busy_through_scan", int'(busy_ok), 1);
    chk("j_idle_high", int'(jidle_ok), 1);
    chk("j_trace", int'(jtr), int'(d));
    chk("det_rst_pulses", dr_n, 1);
    chk("done_pulses", done_n, 1);
    chk("done_cycle", done_at, 19);
    chk("hit_count", int'(cnt16), rc);
    chk("hit_valid", int'(hv16), int'(rc != 0));
    chk("first_hit_idx", int'(fi16), rf);
    @(negedge clk);
    chk("idle_busy", int'(busy16), 0);
    chk("idle_done", int'(done16), 0);
    chk("hold_count", int'(cnt16), rc);
  endtask

  task automatic scan32(input logic [31:0] d);
    int rc, rf, c;
    ref_scan(d, 32, 3, rc, rf);
    @(negedge clk);
    start32 = 1'b1; din32 = d;
    @(posedge clk);
    #1 start32 = 1'b0; din32 = $urandom;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done32 && c < 60);
    chk("done32_cycle", c, 35);
    chk("hit_count32", int'(cnt32), rc);
    chk("hit_valid32", int'(hv32), int'(rc != 0));
    chk("first_hit_idx32", int'(fi32), rf);
  endtask

  initial begin
    logic [15:0] d;
    logic [31:0] d32;
    int g, dn;
    rst = 1'b1;
    start16 = 1'b0; din16 = '0;
    start32 = 1'b0; din32 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy16), 0);
    chk("rst_done", int'(done16), 0);
    chk("rst_count", int'(cnt16), 0);
    chk("rst_valid", int'(hv16), 0);
    chk("rst_fi", int'(fi16), 0);
    chk("rst_det_rst", int'(dr16), 0);
    chk("rst_j", int'(j16), 1);
    rst = 1'b0;
    @(negedge clk);

    // Directed words
    scan16(16'h7DF0, 0);
    scan16(16'hFFFF, 0);
    scan16(16'h0000, 0);
    scan16(16'h003E, 0);
    scan16(16'h7DF0, 8);
    scan32(32'h7DF7DF7D);

    // Reset mid-SHIFT, after the first hit has already been counted
    @(negedge clk);
    start16 = 1'b1; din16 = 16'h7DF0;
    @(posedge clk);
    #1 start16 = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy16), 0);
    chk("mid_rst_count", int'(cnt16), 0);
    chk("mid_rst_valid", int'(hv16), 0);
    chk("mid_rst_fi", int'(fi16), 0);
    chk("mid_rst_j", int'(j16), 1);
    chk("mid_rst_det_rst", int'(dr16), 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done16) dn++;
    end
    chk("mid_rst_no_done", dn, 0);
    scan16(16'h7DF0, 0);

    // Randomized words, often seeded with the pattern somewhere
    for (int k = 0; k < 16; k++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) d[$urandom_range(0, 9) +: 7] = 7'b0111110;
      g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 16)) : 0;
      scan16(d, g);
    end
    for (int k = 0; k < 6; k++) begin
      d32 = $urandom;
      if ($urandom_range(0, 1) == 1) d32[$urandom_range(0, 25) +: 7] = 7'b0111110;
      scan32(d32);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
